rst_seq_ctrl: RTL

Reset sequencer that generates the ordered, stretched active-low reset outputs which feed the per-domain reset synchronizers of the processing system. A chip-level reset or a synchronous software request asserts all outputs together. The sequencer then holds them for a programmable time and releases them one at a time with a fixed gap. It signals completion so the system controller knows every downstream block is out of reset.

---
 rtl/rst_seq_pkg.sv | 26 ++
 rtl/rst_seq_timer.sv | 27 ++
 rtl/rst_seq_ctrl.sv | 95 +++++++++
 3 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and defaults for the reset sequencer: FSM states,
// index sizing helper and the default stretch/gap lengths.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RELEASE,
    ST_DONE
  } seq_state_t;

  localparam int HOLD_CYCLES_DEF = 16;
  localparam int GAP_CYCLES_DEF  = 4;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Up-counter with synchronous clear; term flags the last cycle of a
// limit-cycle interval and the counter wraps to zero on that edge.
module rst_seq_timer #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic             term
);

  logic [CNT_W-1:0] cnt;

  assign term = (cnt == (limit - CNT_W'(1)));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (clr || term) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all active-low outputs asserted for HOLD_CYCLES,
// then releases them in index order spaced by GAP_CYCLES.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_OUTS    = 3,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
  parameter int CNT_W       = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                SW_RST_REQ,
  output logic [NUM_OUTS-1:0] RST_OUT,
  output logic                SEQ_DONE,
  output logic                BUSY
);

  localparam int IDX_W = clog2(NUM_OUTS) + 1;

  seq_state_t       state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] limit;
  logic             timer_clr;
  logic             term;

  // One shared timer: the limit follows the phase being timed.
  assign limit     = (state == ST_HOLD) ? CNT_W'(HOLD_CYCLES) : CNT_W'(GAP_CYCLES);
  assign timer_clr = SW_RST_REQ || (state == ST_DONE);

  rst_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (timer_clr),
    .limit (limit),
    .term  (term)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= ST_HOLD;
      idx      <= '0;
      RST_OUT  <= '0;
      SEQ_DONE <= 1'b0;
      BUSY     <= 1'b1;
    end else if (SW_RST_REQ) begin
      // Software request beats any release scheduled for this edge.
      state    <= ST_HOLD;
      idx      <= '0;
      RST_OUT  <= '0;
      SEQ_DONE <= 1'b0;
      BUSY     <= 1'b1;
    end else begin
      case (state)
        ST_HOLD: begin
          if (term) begin
            RST_OUT[0] <= 1'b1;
            idx        <= IDX_W'(1);
            if (NUM_OUTS == 1) begin
              state    <= ST_DONE;
              SEQ_DONE <= 1'b1;
              BUSY     <= 1'b0;
            end else begin
              state <= ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (term) begin
            for (int i = 0; i < NUM_OUTS; i++) begin
              if (idx == IDX_W'(i)) RST_OUT[i] <= 1'b1;
            end
            idx <= idx + IDX_W'(1);
            if (idx == IDX_W'(NUM_OUTS - 1)) begin
              state    <= ST_DONE;
              SEQ_DONE <= 1'b1;
              BUSY     <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          RST_OUT  <= '1;
          SEQ_DONE <= 1'b1;
          BUSY     <= 1'b0;
        end
        default: begin
          state <= ST_HOLD;
        end
      endcase
    end
  end

endmodule
